// File: rtl/counter_apb_ctrl.sv
// counter_apb_ctrl: APB-programmable up-counter with periodic / one-shot modes.
// Registers: CTRL 0x00, LIMIT 0x04, STATUS 0x08, COUNT 0x0C (decoded on paddr[7:0]).
// Optional feature macro: COUNTER_APB_CTRL_IRQ_EN (IE bit and registered irq).
// When the macro is undefined, irq is tied low and IE reads 0.
module counter_apb_ctrl #(
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 8,
    parameter int CNT_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic [APB_DATA_WIDTH-1:0] prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic [CNT_WIDTH-1:0]      cnt,
    output logic                      cout,
    output logic                      busy,
    output logic                      irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [CNT_WIDTH-1:0] LIMIT_RST = CNT_WIDTH'(9);

    logic [1:0]           state;
    logic                 en_q;
    logic                 oneshot_q;
    logic [CNT_WIDTH-1:0] limit_q;
    logic                 done_q;
    logic                 done_n;

    logic                 access;
    logic                 wr;
    logic [7:0]           addr8;
    logic                 sel_ctrl;
    logic                 sel_limit;
    logic                 sel_status;
    logic                 sel_count;
    logic                 mapped;
    logic                 ctrl_wr;
    logic                 limit_wr;
    logic                 status_wr;
    logic                 clr;
    logic                 term;
    logic                 os_term;
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                 unused_bits;

    assign access     = psel & penable;
    assign wr         = access & pwrite;
    assign addr8      = paddr[7:0];
    assign sel_ctrl   = (addr8 == 8'h00);
    assign sel_limit  = (addr8 == 8'h04);
    assign sel_status = (addr8 == 8'h08);
    assign sel_count  = (addr8 == 8'h0C);
    assign mapped     = sel_ctrl | sel_limit | sel_status | sel_count;
    assign ctrl_wr    = wr & sel_ctrl;
    assign limit_wr   = wr & sel_limit;
    assign status_wr  = wr & sel_status;
    assign clr        = ctrl_wr & pwdata[2];

    assign pready     = 1'b1;
    assign pslverr    = access & ~mapped;
    assign prdata     = (access & mapped) ? rdata : '0;

    assign term       = (cnt >= limit_q);
    // cout is gated by en_q so a RUN cycle that is already leaving for IDLE holds cnt silently
    assign cout       = (state == S_RUN) & en_q & term & ~clr;
    assign os_term    = cout & oneshot_q;
    assign busy       = (state == S_RUN);

    assign unused_bits = ^{paddr, pwdata};

    // Next DONE value: a cout in the same cycle beats write-1-to-clear
    always_comb begin
        done_n = done_q;
        if (status_wr && pwdata[0]) done_n = 1'b0;
        if (cout) done_n = 1'b1;
    end

`ifdef COUNTER_APB_CTRL_IRQ_EN
    logic ie_q;
    logic ie_n;

    assign ie_n = ctrl_wr ? pwdata[3] : ie_q;

    // IE register and registered interrupt built from next-state DONE/IE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q <= 1'b0;
            irq  <= 1'b0;
        end else begin
            ie_q <= ie_n;
            irq  <= done_n & ie_n;
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read mux for mapped registers; unused bits read as 0
    always_comb begin
        rdata = '0;
        if (sel_ctrl) begin
            rdata[0] = en_q;
            rdata[1] = oneshot_q;
`ifdef COUNTER_APB_CTRL_IRQ_EN
            rdata[3] = ie_q;
`endif
        end else if (sel_limit) begin
            rdata[CNT_WIDTH-1:0] = limit_q;
        end else if (sel_status) begin
            rdata[0] = done_q;
            rdata[1] = busy;
        end else if (sel_count) begin
            rdata[CNT_WIDTH-1:0] = cnt;
        end
    end

    // Control registers; a one-shot terminal clears EN after any same-cycle write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            limit_q   <= LIMIT_RST;
            done_q    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en_q      <= pwdata[0];
                oneshot_q <= pwdata[1];
            end
            if (os_term) en_q <= 1'b0;
            if (limit_wr) limit_q <= pwdata[CNT_WIDTH-1:0];
            done_q <= done_n;
        end
    end

    // FSM and counter: CLR beats terminal, one-shot parks at LIMIT in HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr) cnt <= '0;
                    if (en_q) state <= S_RUN;
                end
                S_RUN: begin
                    if (!en_q) begin
                        state <= S_IDLE;
                        if (clr) cnt <= '0;
                    end else if (clr) begin
                        cnt <= '0;
                    end else if (term) begin
                        if (oneshot_q) begin
                            cnt   <= limit_q;
                            state <= S_HOLD;
                        end else begin
                            cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                S_HOLD: begin
                    if (clr) begin
                        cnt   <= '0;
                        state <= pwdata[0] ? S_RUN : S_IDLE;
                    end else if (!en_q) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_apb_ctrl.sv
// Testbench for counter_apb_ctrl: scoreboard of expected values, inputs driven
// and outputs sampled on the falling clock edge.
module tb_counter_apb_ctrl;

`ifdef COUNTER_APB_CTRL_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic [3:0] cnt;
    logic       cout;
    logic       busy;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    counter_apb_ctrl #(
        .APB_ADDR_WIDTH(8),
        .APB_DATA_WIDTH(8),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .cnt(cnt),
        .cout(cout),
        .busy(busy),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic push_st(input string tag, input int c, input int co, input int b);
        push_exp({tag, "_cnt"}, 32'(c));
        push_exp({tag, "_cout"}, 32'(co));
        push_exp({tag, "_busy"}, 32'(b));
    endtask

    task automatic chk_st();
        pop_chk(32'(cnt));
        pop_chk(32'(cout));
        pop_chk(32'(busy));
    endtask

    task automatic apb_setup(input logic [7:0] a, input logic [7:0] d, input logic w);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
    endtask

    task automatic apb_access();
        penable = 1'b1;
    endtask

    task automatic apb_end();
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        apb_setup(a, d, 1'b1);
        @(negedge clk);
        apb_access();
        apb_end();
    endtask

    task automatic apb_rd(input logic [7:0] a, input logic [31:0] exp_d, input logic exp_err,
                          input string tag);
        push_exp({tag, "_setup"}, 32'd0);
        push_exp({tag, "_data"}, exp_d);
        push_exp({tag, "_err"}, 32'(exp_err));
        @(negedge clk);
        apb_setup(a, 8'h00, 1'b0);
        #1;
        pop_chk(32'(prdata));
        @(negedge clk);
        apb_access();
        #1;
        pop_chk(32'(prdata));
        pop_chk(32'(pslverr));
        apb_end();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00;

        // reset state
        repeat (2) @(negedge clk);
        push_st("rst", 0, 0, 0);
        push_exp("rst_irq", 32'd0);
        chk_st();
        pop_chk(32'(irq));
        rst = 1'b0;
        apb_rd(8'h00, 32'h00, 1'b0, "ctrl_rst");
        apb_rd(8'h04, 32'h09, 1'b0, "limit_rst");
        apb_rd(8'h08, 32'h00, 1'b0, "status_rst");
        apb_rd(8'h0C, 32'h00, 1'b0, "count_rst");

        // periodic mode, LIMIT=9
        apb_wr(8'h00, 8'h01);
        push_st("per_idle", 0, 0, 0);
        for (int i = 0; i < 25; i++)
            push_st($sformatf("per%0d", i), i % 10, (i % 10 == 9) ? 1 : 0, 1);
        repeat (26) begin
            @(negedge clk);
            chk_st();
        end
        apb_rd(8'h08, 32'h03, 1'b0, "per_status");
        apb_wr(8'h00, 8'h00);
        apb_rd(8'h0C, 32'h09, 1'b0, "per_count_held");
        apb_wr(8'h08, 8'h01);
        apb_rd(8'h08, 32'h00, 1'b0, "per_done_w1c");
        apb_wr(8'h00, 8'h04);
        apb_rd(8'h0C, 32'h00, 1'b0, "clr_idle_count");
        apb_rd(8'h00, 32'h00, 1'b0, "clr_reads0");

        // one-shot mode, LIMIT=3
        apb_wr(8'h04, 8'h03);
        apb_wr(8'h00, 8'h03);
        push_st("os_idle", 0, 0, 0);
        push_st("os0", 0, 0, 1);
        push_st("os1", 1, 0, 1);
        push_st("os2", 2, 0, 1);
        push_st("os3", 3, 1, 1);
        push_st("os_hold", 3, 0, 0);
        push_st("os_after1", 3, 0, 0);
        push_st("os_after2", 3, 0, 0);
        repeat (8) begin
            @(negedge clk);
            chk_st();
        end
        apb_rd(8'h00, 32'h02, 1'b0, "os_ctrl");
        apb_rd(8'h08, 32'h01, 1'b0, "os_status");
        apb_rd(8'h0C, 32'h03, 1'b0, "os_count");
        apb_wr(8'h08, 8'h01);
        apb_wr(8'h00, 8'h04);

        // CLR written in the terminal cycle
        apb_wr(8'h00, 8'h01);
        push_st("clrt_idle", 0, 0, 0);
        push_st("clrt0", 0, 0, 1);
        push_st("clrt1", 1, 0, 1);
        push_st("clrt2", 2, 0, 1);
        repeat (4) begin
            @(negedge clk);
            chk_st();
        end
        apb_setup(8'h00, 8'h05, 1'b1);
        @(negedge clk);
        push_exp("clrt_term_cnt", 32'd3);
        pop_chk(32'(cnt));
        apb_access();
        #1;
        push_exp("clrt_no_cout", 32'd0);
        pop_chk(32'(cout));
        apb_end();
        push_st("clrt_after", 0, 0, 1);
        @(negedge clk);
        chk_st();
        apb_rd(8'h08, 32'h02, 1'b0, "clrt_done_unchanged");
        apb_wr(8'h00, 8'h00);
        apb_wr(8'h08, 8'h01);
        apb_wr(8'h00, 8'h04);

        // LIMIT shrink mid-run
        apb_wr(8'h04, 8'h09);
        apb_wr(8'h00, 8'h01);
        push_st("shr_idle", 0, 0, 0);
        for (int k = 0; k < 7; k++)
            push_st($sformatf("shr%0d", k), k, 0, 1);
        repeat (8) begin
            @(negedge clk);
            chk_st();
        end
        apb_setup(8'h04, 8'h05, 1'b1);
        @(negedge clk);
        push_st("shr7", 7, 0, 1);
        chk_st();
        apb_access();
        apb_end();
        push_st("shr_term", 8, 1, 1);
        push_st("shr_wrap0", 0, 0, 1);
        push_st("shr_wrap1", 1, 0, 1);
        repeat (3) begin
            @(negedge clk);
            chk_st();
        end
        apb_wr(8'h00, 8'h00);
        apb_rd(8'h04, 32'h05, 1'b0, "shr_limit");
        apb_wr(8'h08, 8'h01);
        apb_wr(8'h00, 8'h04);

        // LIMIT=0 periodic: cout every RUN cycle, cnt stuck at 0
        apb_wr(8'h04, 8'h00);
        apb_wr(8'h00, 8'h01);
        push_st("lim0_idle", 0, 0, 0);
        for (int k = 0; k < 4; k++)
            push_st($sformatf("lim0_%0d", k), 0, 1, 1);
        repeat (5) begin
            @(negedge clk);
            chk_st();
        end
        apb_wr(8'h00, 8'h00);
        apb_wr(8'h08, 8'h01);

        // APB error responses and idle bus
        @(negedge clk);
        push_exp("prdata_idle", 32'd0);
        pop_chk(32'(prdata));
        apb_rd(8'h10, 32'h00, 1'b1, "unmapped_rd");
        apb_rd(8'h01, 32'h00, 1'b1, "misaligned_rd");
        @(negedge clk);
        apb_setup(8'h10, 8'hFF, 1'b1);
        @(negedge clk);
        apb_access();
        #1;
        push_exp("unmapped_wr_err", 32'd1);
        pop_chk(32'(pslverr));
        apb_end();
        apb_rd(8'h00, 32'h00, 1'b0, "ctrl_after_bad_wr");
        apb_rd(8'h04, 32'h00, 1'b0, "limit_after_bad_wr");

        // IE and irq
        apb_wr(8'h00, 8'h08);
        apb_rd(8'h00, IRQ_ON ? 32'h08 : 32'h00, 1'b0, "ctrl_ie");
        apb_wr(8'h00, 8'h0B);
        repeat (4) @(negedge clk);
        push_exp("irq_done", 32'(IRQ_ON));
        pop_chk(32'(irq));
        apb_rd(8'h08, 32'h01, 1'b0, "irq_status");
        apb_rd(8'h00, IRQ_ON ? 32'h0A : 32'h02, 1'b0, "irq_ctrl");
        apb_wr(8'h08, 8'h01);
        @(negedge clk);
        push_exp("irq_cleared", 32'd0);
        pop_chk(32'(irq));

        // reset in the middle of a run
        apb_wr(8'h04, 8'h07);
        apb_wr(8'h00, 8'h01);
        push_st("mid_idle", 0, 0, 0);
        for (int k = 0; k < 6; k++)
            push_st($sformatf("mid%0d", k), k, 0, 1);
        repeat (7) begin
            @(negedge clk);
            chk_st();
        end
        rst = 1'b1;
        #1;
        push_st("mid_rst", 0, 0, 0);
        push_exp("mid_rst_irq", 32'd0);
        chk_st();
        pop_chk(32'(irq));
        apb_setup(8'h04, 8'h0F, 1'b1);
        apb_access();
        apb_end();
        @(negedge clk);
        rst = 1'b0;
        apb_rd(8'h04, 32'h09, 1'b0, "mid_limit");
        apb_rd(8'h00, 32'h00, 1'b0, "mid_ctrl");
        apb_rd(8'h08, 32'h00, 1'b0, "mid_status");
        apb_rd(8'h0C, 32'h00, 1'b0, "mid_count");
        @(negedge clk);
        push_st("mid_stay_idle", 0, 0, 0);
        chk_st();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_apb_ctrl.md
COUNTER_APB_CTRL -- requirements
Module: counter_apb_ctrl

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 8, APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 8, APB data width.
REQ-003 SHALL have parameter CNT_WIDTH, default 4, counter width; legal range 1..APB_DATA_WIDTH.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports psel, penable, pwrite, inputs, 1 each, APB control.
REQ-007 SHALL have ports paddr (input, APB_ADDR_WIDTH) and pwdata (input, APB_DATA_WIDTH).
REQ-008 SHALL have ports prdata (output, APB_DATA_WIDTH), pready (output, 1), and pslverr (output, 1).
REQ-009 SHALL have port cnt, output, CNT_WIDTH, current count.
REQ-010 SHALL have port cout, output, 1, one-cycle terminal-count pulse.
REQ-011 SHALL have port busy, output, 1, high in state RUN.
REQ-012 SHALL have port irq, output, 1, interrupt.

Function
REQ-013 SHALL tie pready to 1, giving zero-wait-state access; a transfer occurs when psel&penable.
REQ-014 SHALL decode the register map on paddr[7:0] as follows:
- 0x00 CTRL: [0] EN, [1] ONESHOT, [2] CLR (write-1 pulse, reads 0), [3] IE.
- 0x04 LIMIT: [CNT_WIDTH-1:0], reset value 9.
- 0x08 STATUS: [0] DONE (sticky, write-1-to-clear), [1] BUSY (read-only).
- 0x0C COUNT: read-only, returns cnt.
REQ-015 SHALL read unused bits as 0; unmapped addresses SHALL return pslverr=1 and prdata=0, and writes to them SHALL be ignored.
REQ-016 SHALL drive prdata combinationally during the access phase, and 0 otherwise.
REQ-017 SHALL implement the state machine IDLE/RUN/HOLD:
- IDLE->RUN on EN=1.
- RUN->IDLE on EN=0, with cnt held.
- RUN->HOLD at one-shot terminal.
- HOLD->IDLE on CLR or EN=0.
- HOLD->RUN on CLR with EN=1.
REQ-018 SHALL increment cnt by 1 every cycle in RUN; the terminal condition is cnt>=LIMIT.
REQ-019 SHALL, at terminal in periodic mode (ONESHOT=0), assert cout for one cycle, load cnt=0, and stay in RUN, giving a period of LIMIT+1 cycles.
REQ-020 SHALL, at terminal in one-shot mode, assert cout for one cycle, hold cnt=LIMIT, clear EN, and enter HOLD.
REQ-021 SHALL set DONE in the cycle following any cout.
REQ-022 SHALL, with LIMIT=0 in periodic mode, assert cout every RUN cycle with cnt constantly 0.
REQ-023 SHALL apply a LIMIT write on the next cycle; if the new LIMIT is <= cnt, the next RUN cycle is terminal.
REQ-024 SHALL, on CLR, load cnt=0 with no cout; CLR SHALL win over a simultaneous terminal.
REQ-025 SHALL give a DONE set priority over a same-cycle write-1-to-clear.
REQ-026 SHALL take the EN and CLR of a single CTRL write together, so that CLR applies first and the count then starts from 0 in RUN.
REQ-027 SHALL never wrap cnt past 2^CNT_WIDTH-1 other than via the terminal condition.

Reset
REQ-028 SHALL, while rst=1 and asynchronously on assertion, force:
- state IDLE, cnt=0, cout=0, busy=0, irq=0, DONE=0.
- EN=0, ONESHOT=0, IE=0, LIMIT=9.
REQ-029 SHALL abort any in-flight count on reset; an APB access in flight SHALL have no effect.
REQ-030 SHALL release reset synchronously to clk, with the first increment no earlier than the second clk edge after release with EN written.

Configuration
REQ-031 SHALL, with COUNTER_APB_CTRL_IRQ_EN defined, drive irq = DONE & IE as a registered output, with IE read/write.
REQ-032 SHALL, without COUNTER_APB_CTRL_IRQ_EN, tie irq to 0 and have IE read as 0 with writes ignored; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL cover periodic mode: reset, write CTRL=0x01 -> cnt 0..9 repeating, cout every 10th cycle coincident with cnt=9, DONE=1.
REQ-034 SHALL cover one-shot mode: LIMIT=3, CTRL=0x03 -> cout once at cnt=3, cnt holds 3, busy=0, CTRL reads 0x02.
REQ-035 SHALL cover CLR at terminal: CLR written in the cycle cnt=LIMIT -> cnt=0, no cout, DONE unchanged.
REQ-036 SHALL cover a LIMIT shrink mid-run: at cnt=7 write LIMIT=5 -> next cycle terminal, cout=1, cnt->0.
REQ-037 SHALL cover APB error and irq:
- Read 0x10 -> pslverr=1, prdata=0.
- With the macro defined: IE=1 and DONE -> irq=1; write STATUS=0x01 -> irq=0 next cycle.
REQ-038 SHALL cover reset mid-operation: rst pulse at cnt=5 -> cnt=0, LIMIT=9, busy=0 immediately, before any clk edge.
